// File: rtl/udt_pkg.sv
// rtl/udt_pkg.sv - shared UDT header types, parser states and byte-order helper
package udt_pkg;

   localparam int UDT_HDR_BYTES = 16;

   typedef enum logic [1:0] {
      H0   = 2'd0,
      H1   = 2'd1,
      PAY  = 2'd2,
      DROP = 2'd3
   } rx_state_e;

   typedef struct packed {
      logic        is_ctrl;
      logic [31:0] word0;
      logic [31:0] word1;
      logic [31:0] word2;
      logic [31:0] word3;
   } udt_hdr_t;

   // Lane 0 carries the first wire byte, UDT words are big-endian.
   function automatic logic [31:0] be_word(input logic [31:0] lanes);
      return {lanes[7:0], lanes[15:8], lanes[23:16], lanes[31:24]};
   endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - one-deep registered stream slice (64b data, keep, last)
module axis_reg_slice (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_s_tvalid,
   output logic        o_s_tready,
   input  logic [63:0] i_s_tdata,
   input  logic [7:0]  i_s_tkeep,
   input  logic        i_s_tlast,
   output logic        o_m_tvalid,
   input  logic        i_m_tready,
   output logic [63:0] o_m_tdata,
   output logic [7:0]  o_m_tkeep,
   output logic        o_m_tlast
);

   logic        r_valid;
   logic [63:0] r_data;
   logic [7:0]  r_keep;
   logic        r_last;

   // Refill in the same cycle the held beat drains keeps one beat per cycle.
   assign o_s_tready = !r_valid || i_m_tready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_keep  <= '0;
         r_last  <= 1'b0;
      end else if (i_s_tvalid && o_s_tready) begin
         r_valid <= 1'b1;
         r_data  <= i_s_tdata;
         r_keep  <= i_s_tkeep;
         r_last  <= i_s_tlast;
      end else if (i_m_tready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_m_tvalid = r_valid;
   assign o_m_tdata  = r_data;
   assign o_m_tkeep  = r_keep;
   assign o_m_tlast  = r_last;

endmodule

// File: rtl/udt_rx_pkt_parser.sv
// rtl/udt_rx_pkt_parser.sv - filters UDP RX datagrams and splits UDT header from payload
module udt_rx_pkt_parser
   import udt_pkg::*;
#(
   parameter logic [31:0] FPGA_IP_SRC   = 32'hc0a8006f,
   parameter logic [31:0] FPGA_IP_BCAST = 32'hc0a800ff,
   parameter logic [15:0] PORT          = 16'd10086
) (
   input  logic        udp_clk,
   input  logic        udp_areset,
   input  logic        udp_rx_tvalid,
   output logic        udp_rx_tready,
   input  logic [63:0] udp_rx_tdata,
   input  logic [7:0]  udp_rx_tkeep,
   input  logic        udp_rx_tlast,
   input  logic [31:0] udp_rx_ip_src,
   input  logic [31:0] udp_rx_ip_dest,
   input  logic [15:0] udp_rx_port_src,
   input  logic [15:0] udp_rx_port_dest,
   output logic        hdr_valid,
   input  logic        hdr_ready,
   output logic        hdr_is_ctrl,
   output logic [31:0] hdr_word0,
   output logic [31:0] hdr_word1,
   output logic [31:0] hdr_word2,
   output logic [31:0] hdr_word3,
   output logic [31:0] hdr_ip_src,
   output logic [15:0] hdr_port_src,
   output logic        hdr_has_payload,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [63:0] m_axis_tdata,
   output logic [7:0]  m_axis_tkeep,
   output logic        m_axis_tlast,
   output logic [31:0] stat_pkt_ok,
   output logic [31:0] stat_pkt_drop
);

   rx_state_e   r_state;
   // Beat-0 fields are staged so a still-pending header stays stable.
   logic [31:0] r_w0;
   logic [31:0] r_w1;
   logic [31:0] r_ip_src;
   logic [15:0] r_port_src;
   udt_hdr_t    r_hdr;
   logic [31:0] r_hdr_ip;
   logic [15:0] r_hdr_port;
   logic        r_hdr_valid;
   logic        r_hdr_has_payload;
   logic [31:0] r_ok;
   logic [31:0] r_drop;

   logic        w_accept;
   logic        w_dest_ok;
   logic        w_slice_valid;
   logic        w_slice_ready;

   assign w_dest_ok = (udp_rx_port_dest == PORT) &&
                      ((udp_rx_ip_dest == FPGA_IP_SRC) || (udp_rx_ip_dest == FPGA_IP_BCAST));

   always_comb begin
      udp_rx_tready = 1'b1;
      case (r_state)
         H1:      udp_rx_tready = !r_hdr_valid || hdr_ready;
         PAY:     udp_rx_tready = w_slice_ready;
         default: udp_rx_tready = 1'b1;
      endcase
   end

   assign w_accept      = udp_rx_tvalid && udp_rx_tready;
   assign w_slice_valid = (r_state == PAY) && udp_rx_tvalid;

   always_ff @(posedge udp_clk) begin
      if (udp_areset) begin
         r_state           <= H0;
         r_w0              <= '0;
         r_w1              <= '0;
         r_ip_src          <= '0;
         r_port_src        <= '0;
         r_hdr             <= '0;
         r_hdr_ip          <= '0;
         r_hdr_port        <= '0;
         r_hdr_valid       <= 1'b0;
         r_hdr_has_payload <= 1'b0;
         r_ok              <= '0;
         r_drop            <= '0;
      end else begin
         if (r_hdr_valid && hdr_ready)
            r_hdr_valid <= 1'b0;
         if (w_accept) begin
            case (r_state)
               H0: begin
                  r_w0       <= be_word(udp_rx_tdata[31:0]);
                  r_w1       <= be_word(udp_rx_tdata[63:32]);
                  r_ip_src   <= udp_rx_ip_src;
                  r_port_src <= udp_rx_port_src;
                  if (!w_dest_ok || udp_rx_tlast) begin
                     r_drop  <= r_drop + 32'd1;
                     r_state <= udp_rx_tlast ? H0 : DROP;
                  end else begin
                     r_state <= H1;
                  end
               end
               H1: begin
                  if (udp_rx_tkeep != 8'hFF) begin
                     r_drop  <= r_drop + 32'd1;
                     r_state <= udp_rx_tlast ? H0 : DROP;
                  end else begin
                     r_hdr <= udt_hdr_t'{
                        is_ctrl: r_w0[31],
                        word0:   r_w0,
                        word1:   r_w1,
                        word2:   be_word(udp_rx_tdata[31:0]),
                        word3:   be_word(udp_rx_tdata[63:32])
                     };
                     r_hdr_ip          <= r_ip_src;
                     r_hdr_port        <= r_port_src;
                     r_hdr_has_payload <= !udp_rx_tlast;
                     r_hdr_valid       <= 1'b1;
                     r_ok              <= r_ok + 32'd1;
                     r_state           <= udp_rx_tlast ? H0 : PAY;
                  end
               end
               PAY: if (udp_rx_tlast) r_state <= H0;
               default: if (udp_rx_tlast) r_state <= H0;
            endcase
         end
      end
   end

   axis_reg_slice u_pay_slice (
      .i_clk      (udp_clk),
      .i_rst      (udp_areset),
      .i_s_tvalid (w_slice_valid),
      .o_s_tready (w_slice_ready),
      .i_s_tdata  (udp_rx_tdata),
      .i_s_tkeep  (udp_rx_tkeep),
      .i_s_tlast  (udp_rx_tlast),
      .o_m_tvalid (m_axis_tvalid),
      .i_m_tready (m_axis_tready),
      .o_m_tdata  (m_axis_tdata),
      .o_m_tkeep  (m_axis_tkeep),
      .o_m_tlast  (m_axis_tlast)
   );

   assign hdr_valid       = r_hdr_valid;
   assign hdr_is_ctrl     = r_hdr.is_ctrl;
   assign hdr_word0       = r_hdr.word0;
   assign hdr_word1       = r_hdr.word1;
   assign hdr_word2       = r_hdr.word2;
   assign hdr_word3       = r_hdr.word3;
   assign hdr_ip_src      = r_hdr_ip;
   assign hdr_port_src    = r_hdr_port;
   assign hdr_has_payload = r_hdr_has_payload;
   assign stat_pkt_ok     = r_ok;
   assign stat_pkt_drop   = r_drop;

endmodule

// File: tb/tb_udt_rx_pkt_parser.sv
// tb/tb_udt_rx_pkt_parser.sv - randomized self-checking bench with datagram-level reference model
module tb_udt_rx_pkt_parser;

   localparam logic [31:0] IP_LOC = 32'hc0a8006f;
   localparam logic [31:0] IP_BC  = 32'hc0a800ff;
   localparam logic [15:0] PORT   = 16'd10086;

   logic        clk = 1'b0;
   logic        udp_areset = 1'b1;
   logic        udp_rx_tvalid = 1'b0;
   logic        udp_rx_tready;
   logic [63:0] udp_rx_tdata = '0;
   logic [7:0]  udp_rx_tkeep = '0;
   logic        udp_rx_tlast = 1'b0;
   logic [31:0] udp_rx_ip_src = '0;
   logic [31:0] udp_rx_ip_dest = '0;
   logic [15:0] udp_rx_port_src = '0;
   logic [15:0] udp_rx_port_dest = '0;
   logic        hdr_valid;
   logic        hdr_ready = 1'b1;
   logic        hdr_is_ctrl;
   logic [31:0] hdr_word0, hdr_word1, hdr_word2, hdr_word3, hdr_ip_src;
   logic [15:0] hdr_port_src;
   logic        hdr_has_payload;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic [63:0] m_axis_tdata;
   logic [7:0]  m_axis_tkeep;
   logic        m_axis_tlast;
   logic [31:0] stat_pkt_ok, stat_pkt_drop;

   udt_rx_pkt_parser dut (
      .udp_clk          (clk),
      .udp_areset       (udp_areset),
      .udp_rx_tvalid    (udp_rx_tvalid),
      .udp_rx_tready    (udp_rx_tready),
      .udp_rx_tdata     (udp_rx_tdata),
      .udp_rx_tkeep     (udp_rx_tkeep),
      .udp_rx_tlast     (udp_rx_tlast),
      .udp_rx_ip_src    (udp_rx_ip_src),
      .udp_rx_ip_dest   (udp_rx_ip_dest),
      .udp_rx_port_src  (udp_rx_port_src),
      .udp_rx_port_dest (udp_rx_port_dest),
      .hdr_valid        (hdr_valid),
      .hdr_ready        (hdr_ready),
      .hdr_is_ctrl      (hdr_is_ctrl),
      .hdr_word0        (hdr_word0),
      .hdr_word1        (hdr_word1),
      .hdr_word2        (hdr_word2),
      .hdr_word3        (hdr_word3),
      .hdr_ip_src       (hdr_ip_src),
      .hdr_port_src     (hdr_port_src),
      .hdr_has_payload  (hdr_has_payload),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tkeep     (m_axis_tkeep),
      .m_axis_tlast     (m_axis_tlast),
      .stat_pkt_ok      (stat_pkt_ok),
      .stat_pkt_drop    (stat_pkt_drop)
   );

   always #3 clk = ~clk;

   typedef struct {
      logic [31:0] w0, w1, w2, w3, ip;
      logic [15:0] port;
      logic        has_pay;
   } exp_hdr_t;

   typedef struct {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } exp_beat_t;

   exp_hdr_t  hq[$];
   exp_beat_t pq[$];
   int n_vec = 0, n_err = 0;
   int exp_ok = 0, exp_drop = 0;
   int hdr_mode = 0, pay_mode = 0;
   bit gaps = 0;
   int n_hdr_seen = 0, n_pay_seen = 0;
   logic [7:0] last_keep_seen = '0;
   logic last_ctrl_seen = 1'b0;
   bit bp_done = 0;
   int st, bp_st, base_h, base_p;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Mode 0 always ready, 1 random 50%, 2 held low.
   always @(posedge clk) begin
      #1;
      hdr_ready     = (hdr_mode == 0) ? 1'b1 : (hdr_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_axis_tready = (pay_mode == 0) ? 1'b1 : (pay_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   always @(negedge clk) begin : mon
      exp_hdr_t  eh;
      exp_beat_t eb;
      if (!udp_areset) begin
         if (hdr_valid && hdr_ready) begin
            n_hdr_seen++;
            last_ctrl_seen = hdr_is_ctrl;
            if (hq.size() == 0) chk("hdr_unexpected", 1, 0);
            else begin
               eh = hq.pop_front();
               chk("hdr_word0", hdr_word0, eh.w0);
               chk("hdr_word1", hdr_word1, eh.w1);
               chk("hdr_word2", hdr_word2, eh.w2);
               chk("hdr_word3", hdr_word3, eh.w3);
               chk("hdr_is_ctrl", hdr_is_ctrl, eh.w0[31]);
               chk("hdr_ip_src", hdr_ip_src, eh.ip);
               chk("hdr_port_src", hdr_port_src, eh.port);
               chk("hdr_has_payload", hdr_has_payload, eh.has_pay);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            n_pay_seen++;
            last_keep_seen = m_axis_tkeep;
            if (pq.size() == 0) chk("pay_unexpected", 1, 0);
            else begin
               eb = pq.pop_front();
               chk("pay_tdata", m_axis_tdata, eb.data);
               chk("pay_tkeep", m_axis_tkeep, eb.keep);
               chk("pay_tlast", m_axis_tlast, eb.last);
            end
         end
      end
   end

   // Model: accepted iff port/IP match and datagram holds the full 16-byte header.
   task automatic send_pkt(input int len, input logic [31:0] w0, input logic [31:0] ipd,
                           input logic [15:0] pd, input int max_beats, output int stalls);
      logic [7:0] b[$];
      exp_hdr_t   h;
      exp_beat_t  pb;
      logic [31:0] ips;
      logic [15:0] pts;
      logic hs;
      int nb, to;
      stalls = 0;
      for (int i = 0; i < len; i++) b.push_back(8'($urandom));
      if (len >= 4) begin
         b[0] = w0[31:24]; b[1] = w0[23:16]; b[2] = w0[15:8]; b[3] = w0[7:0];
      end
      ips = $urandom;
      pts = 16'($urandom);
      if (pd == PORT && (ipd == IP_LOC || ipd == IP_BC) && len >= 16) begin
         exp_ok++;
         h.w0 = {b[0], b[1], b[2], b[3]};
         h.w1 = {b[4], b[5], b[6], b[7]};
         h.w2 = {b[8], b[9], b[10], b[11]};
         h.w3 = {b[12], b[13], b[14], b[15]};
         h.ip = ips;
         h.port = pts;
         h.has_pay = (len > 16);
         hq.push_back(h);
         for (int off = 16; off < len; off += 8) begin
            pb.data = '0;
            pb.keep = '0;
            for (int j = 0; j < 8; j++)
               if (off + j < len) begin
                  pb.data[8*j +: 8] = b[off + j];
                  pb.keep[j] = 1'b1;
               end
            pb.last = (off + 8 >= len);
            pq.push_back(pb);
         end
      end else begin
         exp_drop++;
      end
      nb = (len + 7) / 8;
      for (int k = 0; k < nb && k < max_beats; k++) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         udp_rx_tdata = '0;
         udp_rx_tkeep = '0;
         for (int j = 0; j < 8; j++)
            if (k*8 + j < len) begin
               udp_rx_tdata[8*j +: 8] = b[k*8 + j];
               udp_rx_tkeep[j] = 1'b1;
            end
         udp_rx_tlast     = (k == nb - 1);
         udp_rx_ip_src    = ips;
         udp_rx_port_src  = pts;
         udp_rx_ip_dest   = ipd;
         udp_rx_port_dest = pd;
         udp_rx_tvalid    = 1'b1;
         to = 0;
         do begin
            @(negedge clk);
            hs = udp_rx_tready;
            if (!hs) stalls++;
            @(posedge clk);
            #1;
            to++;
         end while (!hs && to < 1000);
         udp_rx_tvalid = 1'b0;
         if (!hs) begin
            chk("rx_handshake_timeout", 0, 1);
            return;
         end
      end
   endtask

   task automatic wait_idle(input string tag);
      int to = 0;
      while ((hq.size() != 0 || pq.size() != 0) && to < 3000) begin
         @(posedge clk); #1; to++;
      end
      chk({tag, "_drain_timeout"}, (to >= 3000), 0);
      repeat (3) begin @(posedge clk); #1; end
      chk({tag, "_stat_ok"}, stat_pkt_ok, 32'(exp_ok));
      chk({tag, "_stat_drop"}, stat_pkt_drop, 32'(exp_drop));
      chk({tag, "_idle_hdr_valid"}, hdr_valid, 0);
      chk({tag, "_idle_m_tvalid"}, m_axis_tvalid, 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      udp_areset = 1'b0;
      @(negedge clk);
      chk("rst_hdr_valid", hdr_valid, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_stat_ok", stat_pkt_ok, 0);
      chk("rst_stat_drop", stat_pkt_drop, 0);
      chk("rst_hdr_word0", hdr_word0, 0);
      chk("rst_m_tdata", m_axis_tdata, 0);
      chk("rst_rx_tready", udp_rx_tready, 1);
      @(posedge clk); #1;

      base_p = n_pay_seen;
      send_pkt(36, 32'h0000_0123, IP_LOC, PORT, 99, st);
      wait_idle("data_pkt");
      chk("data_pkt_beats", n_pay_seen - base_p, 3);
      chk("data_pkt_last_keep", last_keep_seen, 8'h0F);
      chk("data_pkt_ok_one", stat_pkt_ok, 1);

      base_p = n_pay_seen;
      send_pkt(16, 32'h8002_0000, IP_BC, PORT, 99, st);
      wait_idle("ctrl_pkt");
      chk("ctrl_pkt_no_payload", n_pay_seen - base_p, 0);
      chk("ctrl_pkt_is_ctrl", last_ctrl_seen, 1);

      base_h = n_hdr_seen;
      send_pkt(32, $urandom, IP_LOC, 16'd10087, 99, st);
      chk("bad_port_no_stall", st, 0);
      wait_idle("bad_port");
      chk("bad_port_drop_one", stat_pkt_drop, 1);

      send_pkt(8, $urandom, IP_LOC, PORT, 99, st);
      send_pkt(14, $urandom, IP_LOC, PORT, 99, st);
      wait_idle("runt");
      chk("runt_drop_total", stat_pkt_drop, 3);
      chk("no_hdr_for_drops", n_hdr_seen - base_h, 0);

      hdr_mode = 2;
      pay_mode = 1;
      fork
         begin
            send_pkt(24, 32'h0000_0aaa, IP_LOC, PORT, 99, bp_st);
            send_pkt(40, 32'h0000_0bbb, IP_LOC, PORT, 99, bp_st);
            bp_done = 1;
         end
      join_none
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk("bp_h1_stall_tready", udp_rx_tready, 0);
      chk("bp_hdr1_held", hdr_valid, 1);
      chk("bp_hdr1_word0", hdr_word0, 32'h0000_0aaa);
      @(posedge clk); #1;
      hdr_mode = 1;
      for (int i = 0; i < 2000 && !bp_done; i++) begin @(posedge clk); #1; end
      chk("bp_send_done", bp_done, 1);
      wait_idle("backpressure");

      hdr_mode = 0;
      pay_mode = 2;
      send_pkt(64, $urandom, IP_LOC, PORT, 3, st);
      @(negedge clk);
      chk("mid_pay_slice_full", m_axis_tvalid, 1);
      @(posedge clk); #1;
      udp_areset = 1'b1;
      @(posedge clk); #1;
      udp_areset = 1'b0;
      hq.delete();
      pq.delete();
      exp_ok = 0;
      exp_drop = 0;
      @(negedge clk);
      chk("mid_rst_hdr_valid", hdr_valid, 0);
      chk("mid_rst_m_tvalid", m_axis_tvalid, 0);
      chk("mid_rst_stat_ok", stat_pkt_ok, 0);
      chk("mid_rst_stat_drop", stat_pkt_drop, 0);
      chk("mid_rst_rx_tready", udp_rx_tready, 1);
      @(posedge clk); #1;
      pay_mode = 0;
      send_pkt(40, $urandom, IP_LOC, PORT, 99, st);
      wait_idle("post_reset");

      gaps = 1;
      for (int n = 0; n < 60; n++) begin
         logic [31:0] ipd;
         logic [15:0] pd;
         hdr_mode = $urandom_range(0, 1);
         pay_mode = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0:       ipd = IP_BC;
            1:       ipd = $urandom;
            default: ipd = IP_LOC;
         endcase
         pd = ($urandom_range(0, 4) == 0) ? 16'($urandom) : PORT;
         send_pkt($urandom_range(1, 72), $urandom, ipd, pd, 99, st);
      end
      hdr_mode = 1;
      pay_mode = 1;
      wait_idle("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
